// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, single-cycle ALU, iterative shift-add
// multiplier, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_alusrc,
  input  logic        ex_regdst,
  input  logic [3:0]  ex_aluop,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic [31:0] ex_imm,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic        mem_memtoreg,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        ex_busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [3:0]       hold_ctl_q, hold_ctl_d;
  logic [4:0]       hold_rd_q, hold_rd_d;
  logic [3:0]       mem_ctl_q, mem_ctl_d;
  logic [31:0]      mem_result_q, mem_result_d;
  logic [31:0]      mem_store_q, mem_store_d;
  logic [4:0]       mem_rd_q, mem_rd_d;

  logic [31:0] op_a, fwd_rt, op_b, alu_y;
  logic [4:0]  dest;
  logic [3:0]  ex_ctl;

  // MEM result has priority over WB; r0 is never forwarded.
  function automatic logic [31:0] forward(input logic [4:0] src, input logic [31:0] idex_val,
                                          input logic mem_we, input logic [4:0] mem_dst,
                                          input logic [31:0] mem_val, input logic wb_we,
                                          input logic [4:0] wb_dst, input logic [31:0] wb_val);
    if (mem_we && (mem_dst != 5'd0) && (mem_dst == src)) return mem_val;
    if (wb_we && (wb_dst != 5'd0) && (wb_dst == src)) return wb_val;
    return idex_val;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] sh_val,
                                      input logic [4:0] shamt, input logic [15:0] imm16);
    logic signed [31:0] a_s, b_s, sh_s;
    logic [31:0]        y;
    a_s  = a;
    b_s  = b;
    sh_s = sh_val;
    y    = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SLT:  y = {31'b0, a_s < b_s};
      OP_SLTU: y = {31'b0, a < b};
      OP_SLL:  y = sh_val << shamt;
      OP_SRL:  y = sh_val >> shamt;
      OP_SRA:  y = $unsigned(sh_s >>> shamt);
      OP_LUI:  y = {imm16, 16'h0000};
      default: y = '0;
    endcase
    return y;
  endfunction

  always_comb begin
    op_a   = forward(ex_rs, ex_rs_data, mem_ctl_q[3], mem_rd_q, mem_result_q,
                     wb_regwrite, wb_rd, wb_data);
    fwd_rt = forward(ex_rt, ex_rt_data, mem_ctl_q[3], mem_rd_q, mem_result_q,
                     wb_regwrite, wb_rd, wb_data);
    op_b   = ex_alusrc ? ex_imm : fwd_rt;
    dest   = ex_regdst ? ex_rd : ex_rt;
    ex_ctl = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg};
    alu_y  = alu(ex_aluop, op_a, op_b, fwd_rt, ex_imm[10:6], ex_imm[15:0]);
  end

  // Stall only while a product is pending; DONE releases the upstream stages.
  assign ex_busy = rst_n && ((state_q == RUN) || ((state_q == IDLE) && (ex_aluop == OP_MUL)));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    hold_ctl_d   = hold_ctl_q;
    hold_rd_d    = hold_rd_q;
    mem_ctl_d    = '0;
    mem_result_d = '0;
    mem_store_d  = '0;
    mem_rd_d     = '0;
    case (state_q)
      IDLE: begin
        if (ex_aluop == OP_MUL) begin
          mcand_d    = op_a;
          mplier_d   = op_b;
          acc_d      = '0;
          count_d    = '0;
          hold_ctl_d = ex_ctl;
          hold_rd_d  = dest;
          state_d    = RUN;
        end else begin
          mem_ctl_d    = ex_ctl;
          mem_result_d = alu_y;
          mem_store_d  = fwd_rt;
          mem_rd_d     = dest;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        count_d  = count_q + 1'b1;
        if (count_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        mem_ctl_d    = hold_ctl_q;
        mem_result_d = acc_q;
        mem_rd_d     = hold_rd_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // EX/MEM register and multiplier state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      hold_ctl_q   <= '0;
      hold_rd_q    <= '0;
      mem_ctl_q    <= '0;
      mem_result_q <= '0;
      mem_store_q  <= '0;
      mem_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      hold_ctl_q   <= hold_ctl_d;
      hold_rd_q    <= hold_rd_d;
      mem_ctl_q    <= mem_ctl_d;
      mem_result_q <= mem_result_d;
      mem_store_q  <= mem_store_d;
      mem_rd_q     <= mem_rd_d;
    end
  end

  assign mem_regwrite   = mem_ctl_q[3];
  assign mem_memread    = mem_ctl_q[2];
  assign mem_memwrite   = mem_ctl_q[1];
  assign mem_memtoreg   = mem_ctl_q[0];
  assign mem_alu_result = mem_result_q;
  assign mem_store_data = mem_store_q;
  assign mem_rd         = mem_rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: random and directed stimulus against an arithmetic model
// of forwarding, ALU results and multiply timing.
module tb_ex_stage;

  logic        clk, rst_n;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        ex_busy;

  int n_pass  = 0;
  int n_total = 0;

  // model of the EX/MEM register contents as seen by forwarding
  logic        mdl_regwrite;
  logic [4:0]  mdl_rd;
  logic [31:0] mdl_result;
  logic [31:0] exp_result, exp_store;
  logic [4:0]  exp_rd;
  logic [3:0]  exp_ctl;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
    .ex_aluop(ex_aluop), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .ex_busy(ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint sval(input logic [31:0] v);
    return v[31] ? longint'(v) - (longint'(1) << 32) : longint'(v);
  endfunction

  function automatic logic [31:0] mdl_fwd(input logic [4:0] r, input logic [31:0] d);
    if (mdl_regwrite && r != 5'd0 && mdl_rd == r) return mdl_result;
    if (wb_regwrite && r != 5'd0 && wb_rd == r) return wb_data;
    return d;
  endfunction

  function automatic logic [31:0] mdl_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] rt,
                                          input logic [31:0] imm);
    int          sh;
    longint      s;
    logic [63:0] p;
    sh = int'(imm[10:6]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sval(a) < sval(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return rt << sh;
      4'd9:  return rt >> sh;
      4'd10: begin s = sval(rt) >>> sh; return s[31:0]; end
      4'd11: return {imm[15:0], 16'h0000};
      4'd12: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_in();
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0;
    ex_alusrc = 0; ex_regdst = 0; ex_aluop = 4'd0;
    ex_rs_data = 0; ex_rt_data = 0; ex_imm = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic [31:0] imm, input logic alusrc, input logic regdst,
                        input logic [3:0] ctl);
    ex_aluop = op; ex_rs = rs; ex_rt = rt; ex_rd = rd;
    ex_rs_data = rs_d; ex_rt_data = rt_d; ex_imm = imm;
    ex_alusrc = alusrc; ex_regdst = regdst;
    {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} = ctl;
  endtask

  task automatic compute_expect();
    logic [31:0] a, frt, b;
    a          = mdl_fwd(ex_rs, ex_rs_data);
    frt        = mdl_fwd(ex_rt, ex_rt_data);
    b          = ex_alusrc ? ex_imm : frt;
    exp_result = mdl_alu(ex_aluop, a, b, frt, ex_imm);
    exp_store  = frt;
    exp_rd     = ex_regdst ? ex_rd : ex_rt;
    exp_ctl    = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg};
  endtask

  task automatic commit_model();
    mdl_regwrite = exp_ctl[3];
    mdl_rd       = exp_rd;
    mdl_result   = exp_result;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    commit_model();
  endtask

  task automatic reset_model();
    mdl_regwrite = 0; mdl_rd = 0; mdl_result = 0;
  endtask

  task automatic bubble_tick();
    clear_in(); compute_expect(); tick();
  endtask

  // Holds the MUL on ID/EX while busy; reports busy length and stray non-bubbles.
  task automatic run_mul(input bit poke_wb, output int busy_n, output int bad, output bit tmo);
    busy_n = 0; bad = 0; tmo = 1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ex_busy) begin
        busy_n++;
        @(posedge clk); #1;
        if (mem_regwrite || mem_memread || mem_memwrite || mem_memtoreg ||
            mem_alu_result != 0 || mem_rd != 0) bad++;
        if (poke_wb) begin wb_regwrite = 1; wb_rd = ex_rs; wb_data = 32'h1357_9bdf; end
      end else begin
        @(posedge clk); #1;
        tmo = 0;
        break;
      end
    end
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    commit_model();
  endtask

  task automatic test_reset();
    clear_in();
    ex_aluop = 4'b1100;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_alu_result,
         mem_store_data, mem_rd, ex_busy} !== 0)
      $display("FAIL reset_outputs got rw=%b res=%h st=%h rd=%0d busy=%b want all 0",
               mem_regwrite, mem_alu_result, mem_store_data, mem_rd, ex_busy);
    else n_pass++;
    clear_in();
    reset_model();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_sweep();
    logic [31:0] kw;
    bit          hk;
    bubble_tick();
    for (int op = 0; op < 16; op++) begin
      if (op == 12) continue;
      set_op(4'(op), 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0080, 0, 1, 4'b1000);
      compute_expect(); tick();
      n_total++;
      if (mem_alu_result !== exp_result)
        $display("FAIL alu_sweep op=%0d got %h want %h", op, mem_alu_result, exp_result);
      else n_pass++;
      hk = 1;
      case (op)
        0: kw = 32'h0000_0001;
        1: kw = 32'hFFFF_FFFB;
        5: kw = 32'h0000_0000;
        6: kw = 32'h0000_0001;
        7: kw = 32'h0000_0000;
        default: begin hk = 0; kw = 0; end
      endcase
      if (hk) begin
        n_total++;
        if (mem_alu_result !== kw)
          $display("FAIL alu_known op=%0d got %h want %h", op, mem_alu_result, kw);
        else n_pass++;
      end
    end
    set_op(4'b1010, 5'd1, 5'd2, 5'd3, 32'h0, 32'h8000_0000, 32'h0000_0100, 0, 1, 4'b1000);
    compute_expect(); tick();
    n_total++;
    if (mem_alu_result !== 32'hF800_0000)
      $display("FAIL sra got %h want %h", mem_alu_result, 32'hF800_0000);
    else n_pass++;
    set_op(4'b1011, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0000_1234, 1, 0, 4'b1000);
    compute_expect(); tick();
    n_total++;
    if (mem_alu_result !== 32'h1234_0000 || mem_rd !== 5'd2)
      $display("FAIL lui got %h rd=%0d want %h rd=2", mem_alu_result, mem_rd, 32'h1234_0000);
    else n_pass++;
  endtask

  task automatic test_random_alu();
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 14);
      set_op(4'(r >= 12 ? r + 1 : r), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
             1'($urandom), 4'($urandom));
      wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      compute_expect(); tick();
      n_total++;
      if ({mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_rd, mem_alu_result,
           mem_store_data} !== {exp_ctl, exp_rd, exp_result, exp_store})
        $display("FAIL random_alu i=%0d got ctl=%b rd=%0d res=%h st=%h want ctl=%b rd=%0d res=%h st=%h",
                 i, {mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg}, mem_rd,
                 mem_alu_result, mem_store_data, exp_ctl, exp_rd, exp_result, exp_store);
      else n_pass++;
    end
    clear_in();
  endtask

  task automatic test_forward_priority();
    bubble_tick();
    set_op(4'd0, 5'd1, 5'd2, 5'd5, 32'd4, 32'd6, 32'd0, 0, 1, 4'b1000);
    compute_expect(); tick();
    set_op(4'd0, 5'd5, 5'd5, 5'd6, 32'd1, 32'd1, 32'd0, 0, 1, 4'b1000);
    wb_regwrite = 1; wb_rd = 5'd5; wb_data = 32'd99;
    compute_expect(); tick();
    n_total++;
    if (mem_alu_result !== 32'd20 || mem_store_data !== 32'd10)
      $display("FAIL fwd_mem_priority got res=%0d st=%0d want res=20 st=10",
               mem_alu_result, mem_store_data);
    else n_pass++;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    set_op(4'd0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 32'd0, 0, 1, 4'b1000);
    compute_expect(); tick();
    set_op(4'd0, 5'd0, 5'd0, 5'd9, 32'd3, 32'd4, 32'd0, 0, 1, 4'b1000);
    compute_expect(); tick();
    n_total++;
    if (mem_alu_result !== 32'd7)
      $display("FAIL fwd_r0 got %0d want 7", mem_alu_result);
    else n_pass++;
    clear_in();
  endtask

  task automatic test_mul_timing();
    int busy_n, bad;
    bit tmo;
    bubble_tick();
    set_op(4'b1100, 5'd1, 5'd2, 5'd7, 32'h0001_0003, 32'h0000_0005, 32'd0, 0, 1, 4'b1000);
    compute_expect();
    run_mul(0, busy_n, bad, tmo);
    n_total++;
    if (tmo || busy_n != 33)
      $display("FAIL mul_busy_len got %0d timeout=%0d want 33", busy_n, tmo);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL mul_bubbles got %0d non-bubble cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (mem_alu_result !== 32'h0005_000F || mem_regwrite !== 1'b1 || mem_rd !== 5'd7)
      $display("FAIL mul_result got %h rw=%b rd=%0d want 0005000f rw=1 rd=7",
               mem_alu_result, mem_regwrite, mem_rd);
    else n_pass++;
    clear_in();
  endtask

  task automatic test_mul_wrap_and_back_to_back();
    int busy_n, bad;
    bit tmo;
    bubble_tick();
    set_op(4'b1100, 5'd3, 5'd4, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 1, 4'b1000);
    compute_expect();
    run_mul(1, busy_n, bad, tmo);
    n_total++;
    if (tmo || mem_alu_result !== 32'h0000_0001 || busy_n != 33)
      $display("FAIL mul_wrap got %h busy=%0d want 00000001 busy=33", mem_alu_result, busy_n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      set_op(4'b1100, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(8, 15)), $urandom, $urandom, $urandom, 1'($urandom), 1,
             4'b1000);
      compute_expect();
      run_mul(i[0], busy_n, bad, tmo);
      n_total++;
      if (tmo || busy_n != 33 || bad != 0 || mem_alu_result !== exp_result ||
          mem_rd !== exp_rd || mem_regwrite !== 1'b1)
        $display("FAIL mul_b2b i=%0d got %h rd=%0d busy=%0d bad=%0d want %h rd=%0d busy=33",
                 i, mem_alu_result, mem_rd, busy_n, bad, exp_result, exp_rd);
      else n_pass++;
    end
    clear_in();
  endtask

  task automatic test_reset_mid_mul();
    int late;
    bubble_tick();
    set_op(4'b1100, 5'd1, 5'd2, 5'd7, 32'd7, 32'd9, 32'd0, 0, 1, 4'b1000);
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    n_total++;
    if ({mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_alu_result,
         mem_store_data, mem_rd, ex_busy} !== 0)
      $display("FAIL reset_mid_mul got res=%h rd=%0d busy=%b want all 0",
               mem_alu_result, mem_rd, ex_busy);
    else n_pass++;
    clear_in();
    reset_model();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    set_op(4'd0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd1, 32'd0, 0, 1, 4'b1000);
    compute_expect(); tick();
    n_total++;
    if (mem_alu_result !== 32'd2 || mem_regwrite !== 1'b1 || mem_rd !== 5'd4)
      $display("FAIL reset_then_add got %0d rw=%b rd=%0d want 2 rw=1 rd=4",
               mem_alu_result, mem_regwrite, mem_rd);
    else n_pass++;
    late = 0;
    for (int i = 0; i < 36; i++) begin
      bubble_tick();
      if (mem_alu_result != 0 || mem_regwrite) late++;
    end
    n_total++;
    if (late != 0) $display("FAIL reset_no_partial got %0d writes want 0", late);
    else n_pass++;
  endtask

  task automatic test_bubble();
    set_op(4'd0, 5'd3, 5'd4, 5'd5, 32'd11, 32'd22, 32'd0, 0, 1, 4'b1110);
    compute_expect(); tick();
    bubble_tick();
    n_total++;
    if (mem_regwrite !== 0 || mem_memread !== 0 || mem_memwrite !== 0 || mem_alu_result !== 0)
      $display("FAIL bubble got rw=%b rd=%b wr=%b res=%h want 0 0 0 0",
               mem_regwrite, mem_memread, mem_memwrite, mem_alu_result);
    else n_pass++;
  endtask

  initial begin
    reset_model();
    exp_result = 0; exp_store = 0; exp_rd = 0; exp_ctl = 0;
    test_reset();
    test_bubble();
    test_alu_sweep();
    test_forward_priority();
    test_random_alu();
    test_mul_timing();
    test_mul_wrap_and_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
